// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: bus arbiter state encoding and the
// read word returned when a memory transfer is abandoned.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_P = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_arbiter.sv
// Two-channel (instruction fetch / data) arbiter in front of a single
// shared memory port. Requests alternate when both channels are pending,
// each grant waits for MEM_ACK and gives up after TIMEOUT granted cycles.
module bus_arbiter
  import cpu_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] ADDR_Prog,
  input  logic        CS_P,
  input  logic [31:0] ADDR,
  input  logic [31:0] Data_BUS_WRITE,
  input  logic        CS,
  input  logic        WR_RD,
  output logic [31:0] Prog_BUS_READ,
  output logic [31:0] Data_BUS_READ,
  output logic        P_RDY,
  output logic        D_RDY,
  output logic        BUS_ERR,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state, next_state;
  logic             done_p, done_d;
  logic             last_was_d;      // channel granted most recently, 1 = data
  logic [CNT_W-1:0] wait_cnt;

  logic        pend_p, pend_d;
  logic        pick_p, pick_d;
  logic        grant_p, grant_d;
  logic        granted, expired, complete;
  logic [31:0] rd_word;

  // A channel stays blocked after its RDY until the CPU drops CS, so a
  // level request held one cycle too long is not served twice.
  assign pend_p = CS_P && !done_p;
  assign pend_d = CS   && !done_d;

  // Alternate on contention: data wins unless it was the last one served.
  assign pick_d = pend_d && (!pend_p || !last_was_d);
  assign pick_p = pend_p && !pick_d;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; a grant always passes back through IDLE
  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (pick_d)      next_state = GRANT_D;
        else if (pick_p) next_state = GRANT_P;
      end
      GRANT_P, GRANT_D: begin
        if (complete) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: grant strobes, completion and the word to capture
  always_comb begin
    grant_p  = (state == IDLE) && pick_p;
    grant_d  = (state == IDLE) && pick_d;
    granted  = (state == GRANT_P) || (state == GRANT_D);
    expired  = granted && !MEM_ACK && (wait_cnt == CNT_W'(TIMEOUT - 1));
    complete = granted && (MEM_ACK || expired);
    rd_word  = expired ? ERR_DATA : MEM_RDATA;
  end

  // Registered memory port, read registers, completion pulses, wait counter
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      MEM_REQ       <= 1'b0;
      MEM_WE        <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_WDATA     <= '0;
      Prog_BUS_READ <= '0;
      Data_BUS_READ <= '0;
      P_RDY         <= 1'b0;
      D_RDY         <= 1'b0;
      BUS_ERR       <= 1'b0;
      wait_cnt      <= '0;
      last_was_d    <= 1'b0;
    end else begin
      P_RDY   <= 1'b0;
      D_RDY   <= 1'b0;
      BUS_ERR <= 1'b0;
      if (grant_p) begin
        MEM_REQ    <= 1'b1;
        MEM_WE     <= 1'b0;
        MEM_ADDR   <= ADDR_Prog;
        MEM_WDATA  <= '0;
        wait_cnt   <= '0;
        last_was_d <= 1'b0;
      end else if (grant_d) begin
        MEM_REQ    <= 1'b1;
        MEM_WE     <= WR_RD;
        MEM_ADDR   <= ADDR;
        MEM_WDATA  <= Data_BUS_WRITE;
        wait_cnt   <= '0;
        last_was_d <= 1'b1;
      end else if (granted) begin
        if (!MEM_ACK) wait_cnt <= wait_cnt + 1'b1;
        if (complete) begin
          MEM_REQ <= 1'b0;
          MEM_WE  <= 1'b0;
          BUS_ERR <= expired;
          if (state == GRANT_P) begin
            P_RDY         <= 1'b1;
            Prog_BUS_READ <= rd_word;
          end else begin
            D_RDY <= 1'b1;
            if (!MEM_WE) Data_BUS_READ <= rd_word;
          end
        end
      end
    end
  end

  // Done flags: set on the channel's completion edge, cleared while CS is low
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      done_p <= 1'b0;
      done_d <= 1'b0;
    end else begin
      if (!CS_P)                               done_p <= 1'b0;
      else if (complete && state == GRANT_P)   done_p <= 1'b1;
      if (!CS)                                 done_d <= 1'b0;
      else if (complete && state == GRANT_D)   done_d <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a memory responder checks each
// request against a queue of expected accesses, and a completion monitor
// checks every RDY pulse against a queue of expected results.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int NEVER = 1000;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] ADDR_Prog, ADDR, Data_BUS_WRITE, MEM_RDATA;
  logic        CS_P, CS, WR_RD, MEM_ACK;
  logic [31:0] Prog_BUS_READ, Data_BUS_READ, MEM_ADDR, MEM_WDATA;
  logic        P_RDY, D_RDY, BUS_ERR, MEM_REQ, MEM_WE;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } mem_exp_t;

  typedef struct {
    logic        prog;
    logic        err;
    logic [31:0] data;
  } rdy_exp_t;

  mem_exp_t    mem_q[$];
  rdy_exp_t    rdy_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          spurious_ack = 1'b0;
  int          idle_len, last_idle, req_len, last_req_len;
  logic [31:0] exp_dread = 32'h0;
  logic [31:0] exp_pread = 32'h0;

  bus_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .CLK(CLK), .reset(reset),
    .ADDR_Prog(ADDR_Prog), .CS_P(CS_P),
    .ADDR(ADDR), .Data_BUS_WRITE(Data_BUS_WRITE), .CS(CS), .WR_RD(WR_RD),
    .Prog_BUS_READ(Prog_BUS_READ), .Data_BUS_READ(Data_BUS_READ),
    .P_RDY(P_RDY), .D_RDY(D_RDY), .BUS_ERR(BUS_ERR),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Memory responder: validates each new request, ACKs after its delay
  initial begin
    mem_exp_t cur;
    cur.addr = '0; cur.we = 1'b0; cur.wdata = '0; cur.rdata = '0; cur.delay = NEVER;
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    idle_len = 0; last_idle = 0; req_len = 0; last_req_len = 0;
    forever begin
      @(negedge CLK);
      if (MEM_REQ === 1'b1) begin
        if (req_len == 0) begin
          last_idle = idle_len;
          idle_len  = 0;
          if (mem_q.size() == 0) begin
            check("mem_unexpected_req", {31'b0, MEM_REQ}, 32'h0);
            cur.delay = NEVER;
          end else begin
            cur = mem_q.pop_front();
            check("mem_addr", MEM_ADDR, cur.addr);
            check("mem_we", {31'b0, MEM_WE}, {31'b0, cur.we});
            if (cur.we) check("mem_wdata", MEM_WDATA, cur.wdata);
          end
        end
        MEM_ACK   = (req_len == cur.delay);
        MEM_RDATA = MEM_ACK ? cur.rdata : 32'h0BAD_0BAD;
        req_len++;
      end else begin
        if (req_len != 0) last_req_len = req_len;
        req_len   = 0;
        idle_len++;
        MEM_ACK   = spurious_ack;
        MEM_RDATA = spurious_ack ? 32'h5A5A_5A5A : 32'h0;
      end
    end
  end

  // Completion monitor: every RDY pulse must match the next expected result
  initial begin
    rdy_exp_t e;
    forever begin
      @(negedge CLK);
      if (P_RDY === 1'b1 || D_RDY === 1'b1) begin
        if (rdy_q.size() == 0 || (P_RDY === 1'b1 && D_RDY === 1'b1)) begin
          check("rdy_unexpected", {30'b0, P_RDY, D_RDY}, 32'h0);
        end else begin
          e = rdy_q.pop_front();
          check("rdy_channel", {31'b0, P_RDY}, {31'b0, e.prog});
          check("bus_err", {31'b0, BUS_ERR}, {31'b0, e.err});
          if (e.prog) check("prog_rdata", Prog_BUS_READ, e.data);
          else        check("data_rdata", Data_BUS_READ, e.data);
        end
      end else if (BUS_ERR !== 1'b0) begin
        check("bus_err_stray", {31'b0, BUS_ERR}, 32'h0);
      end
    end
  end

  // Wait for a channel's RDY; returns negedges elapsed, optional CS drop
  task automatic wait_rdy(input bit prog, input int max_cyc, input int drop_at, output int lat);
    lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge CLK);
      if (i == drop_at) CS = 1'b0;
      if ((prog ? P_RDY : D_RDY) === 1'b1) begin
        lat = i;
        return;
      end
    end
    check(prog ? "p_rdy_wait" : "d_rdy_wait", {31'b0, prog ? P_RDY : D_RDY}, 32'h1);
  endtask

  task automatic data_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay, input int drop_at,
                           input int exp_lat, input string tag);
    int lat;
    mem_q.push_back('{addr, we, wdata, rdata, delay});
    if (!we) exp_dread = rdata;
    rdy_q.push_back('{1'b0, 1'b0, exp_dread});
    ADDR = addr; WR_RD = we; Data_BUS_WRITE = wdata; CS = 1'b1;
    wait_rdy(1'b0, 40, drop_at, lat);
    CS = 1'b0;
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic both_xfer(input bit prog_first, input logic [31:0] d_rdata, input logic [31:0] p_rdata);
    mem_exp_t md, mp;
    bit got_p, got_d;
    int lat_p, lat_d;
    md = '{32'h0000_0020, 1'b0, 32'h0, d_rdata, 2};
    mp = '{32'h0000_1000, 1'b0, 32'h0, p_rdata, 2};
    if (prog_first) begin
      mem_q.push_back(mp); mem_q.push_back(md);
      rdy_q.push_back('{1'b1, 1'b0, p_rdata}); rdy_q.push_back('{1'b0, 1'b0, d_rdata});
    end else begin
      mem_q.push_back(md); mem_q.push_back(mp);
      rdy_q.push_back('{1'b0, 1'b0, d_rdata}); rdy_q.push_back('{1'b1, 1'b0, p_rdata});
    end
    exp_dread = d_rdata;
    exp_pread = p_rdata;
    ADDR = 32'h0000_0020; WR_RD = 1'b0; ADDR_Prog = 32'h0000_1000;
    CS = 1'b1; CS_P = 1'b1;
    got_p = 1'b0; got_d = 1'b0; lat_p = 0; lat_d = 0;
    for (int i = 1; i <= 40 && !(got_p && got_d); i++) begin
      @(negedge CLK);
      if (D_RDY === 1'b1 && !got_d) begin got_d = 1'b1; lat_d = i; CS = 1'b0; end
      if (P_RDY === 1'b1 && !got_p) begin got_p = 1'b1; lat_p = i; CS_P = 1'b0; end
    end
    CS = 1'b0; CS_P = 1'b0;
    // first grant: 3 granted cycles, RDY at 4; second follows one idle cycle later
    check("both_d_lat", 32'(lat_d), prog_first ? 32'd8 : 32'd4);
    check("both_p_lat", 32'(lat_p), prog_first ? 32'd4 : 32'd8);
    check("both_idle_gap", 32'(last_idle), 32'd1);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    ADDR_Prog = '0; CS_P = 1'b0; ADDR = '0; Data_BUS_WRITE = '0; CS = 1'b0; WR_RD = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_mem_req", {31'b0, MEM_REQ}, 32'h0);
    check("rst_mem_we", {31'b0, MEM_WE}, 32'h0);
    check("rst_mem_addr", MEM_ADDR, 32'h0);
    check("rst_pulses", {29'b0, P_RDY, D_RDY, BUS_ERR}, 32'h0);
    check("rst_prog_read", Prog_BUS_READ, 32'h0);
    check("rst_data_read", Data_BUS_READ, 32'h0);
    reset = 1'b0;
    @(negedge CLK);

    // Contention straight after reset: data first, program after one idle cycle
    both_xfer(1'b0, 32'h0000_7777, 32'h0000_064F);
    @(negedge CLK);

    // Minimum-latency data read
    data_xfer(32'h0000_0010, 1'b0, 32'h0, 32'h0000_22B4, 0, 0, 2, "read_lat");
    @(negedge CLK);
    check("read_req_len", 32'(last_req_len), 32'd1);
    check("read_value", Data_BUS_READ, 32'h0000_22B4);

    // Data was served last, so contention now goes to the program channel
    both_xfer(1'b1, 32'h0000_22B4, 32'h1357_9BDF);
    @(negedge CLK);

    // Write leaves the data read register untouched
    data_xfer(32'h0000_0040, 1'b1, 32'hA5A5_0001, 32'hFFFF_0000, 1, 0, 3, "write_lat");
    @(negedge CLK);
    check("write_keeps_dread", Data_BUS_READ, exp_dread);

    // CS withdrawn mid-grant: transfer still completes with a RDY
    data_xfer(32'h0000_0080, 1'b0, 32'h0, 32'h1234_5678, 3, 2, 5, "drop_cs_lat");
    @(negedge CLK);

    // ACK while idle is ignored
    spurious_ack = 1'b1;
    repeat (4) @(negedge CLK);
    spurious_ack = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle_ack_req", {31'b0, MEM_REQ}, 32'h0);
    check("idle_ack_dread", Data_BUS_READ, exp_dread);
    check("idle_ack_pread", Prog_BUS_READ, exp_pread);

    // Timeout on the program channel: 16 granted cycles, then RDY + BUS_ERR
    mem_q.push_back('{32'h0000_2000, 1'b0, 32'h0, 32'h0, NEVER});
    rdy_q.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF});
    exp_pread = 32'hDEAD_BEEF;
    ADDR_Prog = 32'h0000_2000; CS_P = 1'b1;
    wait_rdy(1'b1, 40, 0, lat);
    CS_P = 1'b0;
    check("timeout_lat", 32'(lat), 32'd17);
    @(negedge CLK);
    check("timeout_req_len", 32'(last_req_len), 32'd16);
    check("timeout_pread", Prog_BUS_READ, 32'hDEAD_BEEF);

    // Reset three cycles into a granted read, then the held CS is re-served
    mem_q.push_back('{32'h0000_0100, 1'b0, 32'h0, 32'h0, NEVER});
    ADDR = 32'h0000_0100; WR_RD = 1'b0; CS = 1'b1;
    repeat (3) @(negedge CLK);
    #2 reset = 1'b1;
    #1 check("rst_async_req", {31'b0, MEM_REQ}, 32'h0);
    check("rst_mid_dread", Data_BUS_READ, 32'h0);
    check("rst_mid_pread", Prog_BUS_READ, 32'h0);
    mem_q.push_back('{32'h0000_0100, 1'b0, 32'h0, 32'h0000_0F0F, 0});
    rdy_q.push_back('{1'b0, 1'b0, 32'h0000_0F0F});
    exp_dread = 32'h0000_0F0F;
    @(negedge CLK);
    reset = 1'b0;
    wait_rdy(1'b0, 40, 0, lat);
    CS = 1'b0;
    check("rst_reserve_lat", 32'(lat), 32'd2);
    repeat (2) @(negedge CLK);

    check("mem_q_left", 32'(mem_q.size()), 32'd0);
    check("rdy_q_left", 32'(rdy_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
